// File: rtl/data_port_router.sv
// data_port_router: registered router from the Aquila core data port to N_CH tag-decoded target channels.
// Build macro ROUTER_TIMEOUT_EN adds a WAIT watchdog that answers a stalled target with an error response.
module data_port_router #(
  parameter int                XLEN           = 32,
  parameter int                N_CH           = 4,
  parameter logic [N_CH*4-1:0] CH_TAGS        = {4'hF, 4'hC, 4'h8, 4'h0},
  parameter int                TIMEOUT_CYCLES = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 p_strobe_i,
  input  logic [XLEN-1:0]      p_addr_i,
  input  logic                 p_rw_i,
  input  logic [XLEN/8-1:0]    p_byte_enable_i,
  input  logic [XLEN-1:0]      p_data_i,
  output logic [XLEN-1:0]      p_data_o,
  output logic                 p_ready_o,
  output logic                 p_err_o,
  output logic                 busy_o,
  output logic [N_CH-1:0]      m_strobe_o,
  output logic [XLEN-1:0]      m_addr_o,
  output logic                 m_rw_o,
  output logic [XLEN/8-1:0]    m_byte_enable_o,
  output logic [XLEN-1:0]      m_data_o,
  input  logic [N_CH*XLEN-1:0] m_data_i,
  input  logic [N_CH-1:0]      m_ready_i,
  input  logic                 err_clr_i,
  output logic                 err_status_o,
  output logic [XLEN-1:0]      err_addr_o,
  output logic [1:0]           state_o
);

  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Handshake: p_strobe_i is a one-cycle request, taken only when nothing is outstanding, and every
  // taken request yields exactly one p_ready_o pulse. m_strobe_o pulses once per mapped request; the
  // selected target answers with m_ready_i on its own lane any cycle after that pulse.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_UNMAP = 2'd2
  } state_t;

  state_t            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic              dec_hit;
  logic [SEL_W-1:0]  dec_idx;
  logic [N_CH-1:0]   dec_oh;
  logic [XLEN-1:0]   ch_data [N_CH];
  logic              sel_ready;
  logic              accept;
  logic              timeout;
  logic              err_evt;
  logic [XLEN-1:0]   err_evt_addr;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch_data
    assign ch_data[g] = m_data_i[XLEN*g +: XLEN];
  end

  // Scan from the top so the lowest matching channel index is the one left selected.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (CH_TAGS[4*i +: 4] == p_addr_i[XLEN-1 -: 4]) begin
        dec_hit = 1'b1;
        dec_idx = SEL_W'(i);
      end
    end
    dec_oh          = '0;
    dec_oh[dec_idx] = 1'b1;
  end

  assign sel_ready = m_ready_i[sel_q];
  // The UNMAP cycle is the error-response cycle, so a fresh request there is taken like in IDLE.
  assign accept    = p_strobe_i && ((state_q == S_IDLE) || (state_q == S_UNMAP));
  assign state_o   = state_q;

`ifdef ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  assign timeout = (state_q == S_WAIT) && !sel_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if ((state_q == S_WAIT) && !sel_ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign err_evt      = (accept && !dec_hit) || timeout;
  assign err_evt_addr = timeout ? m_addr_o : p_addr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      sel_q           <= '0;
      p_data_o        <= '0;
      p_ready_o       <= 1'b0;
      p_err_o         <= 1'b0;
      busy_o          <= 1'b0;
      m_strobe_o      <= '0;
      m_addr_o        <= '0;
      m_rw_o          <= 1'b0;
      m_byte_enable_o <= '0;
      m_data_o        <= '0;
      err_status_o    <= 1'b0;
      err_addr_o      <= '0;
    end else begin
      m_strobe_o <= '0;
      p_ready_o  <= 1'b0;
      p_err_o    <= 1'b0;
      p_data_o   <= '0;

      if (accept) begin
        sel_q           <= dec_idx;
        m_addr_o        <= p_addr_i;
        m_rw_o          <= p_rw_i;
        m_byte_enable_o <= p_byte_enable_i;
        m_data_o        <= p_data_i;
        if (dec_hit) begin
          state_q    <= S_WAIT;
          m_strobe_o <= dec_oh;
          busy_o     <= 1'b1;
        end else begin
          state_q   <= S_UNMAP;
          p_ready_o <= 1'b1;
          p_err_o   <= 1'b1;
        end
      end else begin
        case (state_q)
          S_WAIT: begin
            if (sel_ready) begin
              state_q   <= S_IDLE;
              busy_o    <= 1'b0;
              p_ready_o <= 1'b1;
              p_data_o  <= m_rw_o ? '0 : ch_data[sel_q];
            end else if (timeout) begin
              state_q   <= S_IDLE;
              busy_o    <= 1'b0;
              p_ready_o <= 1'b1;
              p_err_o   <= 1'b1;
            end
          end
          S_UNMAP: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end

      // A clear coinciding with a new error still records the new error.
      if (err_evt) begin
        err_status_o <= 1'b1;
        if (!err_status_o || err_clr_i) err_addr_o <= err_evt_addr;
      end else if (err_clr_i) begin
        err_status_o <= 1'b0;
        err_addr_o   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_port_router.sv
// tb_data_port_router: transaction-level reference model and per-cycle compare for data_port_router.
// Timeout scenarios are exercised when ROUTER_TIMEOUT_EN is defined for the whole build.
module tb_data_port_router;
  localparam int TMO = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         p_strobe_i;
  logic [31:0]  p_addr_i;
  logic         p_rw_i;
  logic [3:0]   p_byte_enable_i;
  logic [31:0]  p_data_i;
  logic [31:0]  p_data_o;
  logic         p_ready_o;
  logic         p_err_o;
  logic         busy_o;
  logic [3:0]   m_strobe_o;
  logic [31:0]  m_addr_o;
  logic         m_rw_o;
  logic [3:0]   m_byte_enable_o;
  logic [31:0]  m_data_o;
  logic [127:0] m_data_i;
  logic [3:0]   m_ready_i;
  logic         err_clr_i;
  logic         err_status_o;
  logic [31:0]  err_addr_o;
  logic [1:0]   state_o;

  data_port_router #(
    .XLEN(32), .N_CH(4), .CH_TAGS({4'hF, 4'hC, 4'h8, 4'h0}), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .p_strobe_i(p_strobe_i), .p_addr_i(p_addr_i), .p_rw_i(p_rw_i),
    .p_byte_enable_i(p_byte_enable_i), .p_data_i(p_data_i),
    .p_data_o(p_data_o), .p_ready_o(p_ready_o), .p_err_o(p_err_o), .busy_o(busy_o),
    .m_strobe_o(m_strobe_o), .m_addr_o(m_addr_o), .m_rw_o(m_rw_o),
    .m_byte_enable_o(m_byte_enable_o), .m_data_o(m_data_o),
    .m_data_i(m_data_i), .m_ready_i(m_ready_i),
    .err_clr_i(err_clr_i), .err_status_o(err_status_o), .err_addr_o(err_addr_o),
    .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- model state / expectations ----------------
  int          vectors = 0;
  int          miscompares = 0;
  bit          chk_en = 0;
  bit          chk_bus = 0;
  logic        exp_ready = 0;
  logic        exp_busy = 0;
  logic [3:0]  exp_mstrobe = '0;
  logic [31:0] exp_maddr = '0;
  logic        exp_mrw = 0;
  logic [3:0]  exp_mbe = '0;
  logic [31:0] exp_mdata = '0;
  logic        mdl_err_status = 0;
  logic [31:0] mdl_err_addr = '0;
  logic        pend_err = 0;
  logic [31:0] pend_err_addr = '0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Address map of the router under test, lowest channel index wins.
  function automatic int decode(input logic [31:0] a);
    logic [3:0] tags [4];
    tags = '{4'h0, 4'h8, 4'hC, 4'hF};
    for (int i = 0; i < 4; i++) if (tags[i] == a[31:28]) return i;
    return -1;
  endfunction

  // Advance one clock; apply the sticky-error rules to whatever happened in the cycle just ended.
  task automatic next_cycle();
    logic        clr;
    logic        e;
    logic [31:0] ea;
    clr = err_clr_i;
    e   = pend_err;
    ea  = pend_err_addr;
    pend_err = 0;
    @(posedge clk_i);
    #1;
    if (!rst_ni) begin
      mdl_err_status = 0;
      mdl_err_addr   = '0;
    end else if (e) begin
      if (!mdl_err_status || clr) mdl_err_addr = ea;
      mdl_err_status = 1;
    end else if (clr) begin
      mdl_err_status = 0;
      mdl_err_addr   = '0;
    end
    p_strobe_i      = 0;
    m_ready_i       = '0;
    err_clr_i       = 0;
    p_addr_i        = $urandom;
    p_data_i        = $urandom;
    p_rw_i          = 1'($urandom_range(0, 1));
    p_byte_enable_i = 4'($urandom_range(0, 15));
    m_data_i        = {$urandom, $urandom, $urandom, $urandom};
    exp_ready       = 0;
    exp_busy        = 0;
    exp_mstrobe     = '0;
    chk_bus         = 0;
  endtask

  // One transaction: cycle 0 is the strobe cycle; returns inside the response cycle.
  task automatic do_txn(input logic [31:0] addr, input logic rw, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int ready_k,
                        input int stray_ch, input int stray_k, input int rst_k,
                        input bit b2b, input bit rand_clr);
    int ch;
    bit timed_out;
    int last_k;
    ch = decode(addr);
    if (!b2b) next_cycle();
    p_strobe_i      = 1;
    p_addr_i        = addr;
    p_rw_i          = rw;
    p_byte_enable_i = be;
    p_data_i        = wdata;
    if (rand_clr) err_clr_i = ($urandom_range(0, 7) == 0);
    if (ch < 0) begin
      pend_err      = 1;
      pend_err_addr = addr;
      next_cycle();
      exp_ready = 1;
      exp_q.push_back({1'b1, 32'h0});
      return;
    end
    timed_out = 0;
    last_k    = ready_k;
`ifdef ROUTER_TIMEOUT_EN
    if (ready_k > TMO) begin
      timed_out = 1;
      last_k    = TMO;
    end
`endif
    for (int k = 1; k <= last_k; k++) begin
      next_cycle();
      exp_busy  = 1;
      chk_bus   = 1;
      exp_maddr = addr;
      exp_mrw   = rw;
      exp_mbe   = be;
      exp_mdata = wdata;
      if (k == 1) exp_mstrobe = 4'(1 << ch);
      if (k == rst_k) begin
        rst_ni         = 0;
        exp_busy       = 0;
        exp_mstrobe    = '0;
        exp_maddr      = '0;
        exp_mrw        = 0;
        exp_mbe        = '0;
        exp_mdata      = '0;
        mdl_err_status = 0;
        mdl_err_addr   = '0;
        next_cycle();
        chk_bus = 1;
        rst_ni  = 1;
        return;
      end
      p_strobe_i = ($urandom_range(0, 5) == 0);
      if (rand_clr) err_clr_i = ($urandom_range(0, 7) == 0);
      if (stray_k == k && stray_ch != ch && stray_ch >= 0) m_ready_i[stray_ch] = 1;
      if (k == ready_k) begin
        m_ready_i[ch]        = 1;
        m_data_i[32*ch +: 32] = rdata;
      end
    end
    if (timed_out) begin
      pend_err      = 1;
      pend_err_addr = addr;
    end
    next_cycle();
    exp_ready = 1;
    exp_q.push_back({timed_out, (timed_out || rw) ? 32'h0 : rdata});
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk_i) begin : cmp
    logic [32:0] e;
    if (chk_en) begin
      check("p_ready", 32'(p_ready_o), 32'(exp_ready));
      if (exp_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL exp_q: got empty queue expected a pending response (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("p_err", 32'(p_err_o), 32'(e[32]));
          check("p_data", p_data_o, e[31:0]);
        end
      end
      check("busy", 32'(busy_o), 32'(exp_busy));
      check("m_strobe", 32'(m_strobe_o), 32'(exp_mstrobe));
      check("err_status", 32'(err_status_o), 32'(mdl_err_status));
      check("err_addr", err_addr_o, mdl_err_addr);
      if (chk_bus) begin
        check("m_addr", m_addr_o, exp_maddr);
        check("m_rw", 32'(m_rw_o), 32'(exp_mrw));
        check("m_be", 32'(m_byte_enable_o), 32'(exp_mbe));
        check("m_data", m_data_o, exp_mdata);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_ni = 1; p_strobe_i = 0; p_addr_i = '0; p_rw_i = 0; p_byte_enable_i = '0;
    p_data_i = '0; m_data_i = '0; m_ready_i = '0; err_clr_i = 0;
    #2 rst_ni = 0;
    next_cycle();
    chk_en  = 1;
    chk_bus = 1;
    check("lit_rst_ready", 32'(p_ready_o), 32'h0);
    check("lit_rst_state", 32'(state_o), 32'h0);
    check("lit_rst_maddr", m_addr_o, 32'h0);
    next_cycle();
    chk_bus = 1;
    rst_ni  = 1;

    // TCM read, ready in cycle 1
    do_txn(32'h0000_0010, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1, -1, 0, 0, 0, 0);
    check("lit_tcm_data", p_data_o, 32'hDEADBEEF);
    check("lit_tcm_err", 32'(p_err_o), 32'h0);

    // device write, ready in cycle 4
    do_txn(32'hC000_0004, 1'b1, 4'hF, 32'h1234_5678, 32'hA5A5_A5A5, 4, -1, 0, 0, 0, 0);
    check("lit_wr_ready", 32'(p_ready_o), 32'h1);
    check("lit_wr_data", p_data_o, 32'h0);

    // unmapped accesses and sticky error
    do_txn(32'h4000_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1, -1, 0, 0, 0, 0);
    check("lit_unmap_err", 32'(p_err_o), 32'h1);
    check("lit_unmap_addr", err_addr_o, 32'h4000_0000);
    do_txn(32'h5000_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1, -1, 0, 0, 0, 0);
    check("lit_unmap2_addr", err_addr_o, 32'h4000_0000);
    next_cycle();
    err_clr_i = 1;
    next_cycle();
    check("lit_clr_status", 32'(err_status_o), 32'h0);

`ifdef ROUTER_TIMEOUT_EN
    do_txn(32'h8000_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1000, -1, 0, 0, 0, 0);
    check("lit_tmo_err", 32'(p_err_o), 32'h1);
    check("lit_tmo_addr", err_addr_o, 32'h8000_0000);
    next_cycle();
    next_cycle();
    next_cycle();
    m_ready_i[1] = 1;
    next_cycle();
    do_txn(32'h8000_0040, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, TMO, -1, 0, 0, 0, 0);
    check("lit_last_wait_err", 32'(p_err_o), 32'h0);
    check("lit_last_wait_data", p_data_o, 32'h0BAD_F00D);
`else
    do_txn(32'h8000_0000, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, 20, -1, 0, 0, 0, 0);
    check("lit_long_wait_data", p_data_o, 32'h0BAD_F00D);
`endif

    // stray ready from ch3 while ch0 is outstanding
    do_txn(32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 5, 3, 2, 0, 0, 0);
    check("lit_stray_data", p_data_o, 32'hCAFE_F00D);

    // reset in cycle 3 of a pending ch1 read, then a clean request
    do_txn(32'h8000_0020, 1'b0, 4'hF, 32'h0, 32'h1111_1111, 10, -1, 0, 3, 0, 0);
    do_txn(32'h8000_0024, 1'b0, 4'h3, 32'h0, 32'h2222_2222, 2, -1, 0, 0, 0, 0);
    check("lit_post_rst_data", p_data_o, 32'h2222_2222);

    // back-to-back request in a response cycle
    do_txn(32'hF000_0008, 1'b0, 4'hF, 32'h0, 32'h3333_4444, 1, -1, 0, 0, 1, 0);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = {4'($urandom_range(0, 15)), 28'($urandom)};
      do_txn(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom,
             $urandom_range(1, 10), $urandom_range(0, 3), $urandom_range(0, 4), 0,
             bit'($urandom_range(0, 1)), 1);
    end
    next_cycle();
    next_cycle();
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
